operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Decode-side initiator for the 8x8 register file: drives the two read addresses (srcA/srcB) and captures the returned operands.
- Patches operands with in-flight results from the execute, memory and writeback stages. The file only updates at posedge, so same-cycle writes are not visible through the read ports.
- Detects load-use hazards and stalls.
- Presents a registered valid/ready operand bundle to the execute stage.

Parameters:
- DW, 8, data width (matches register file).
- RW, 3, register address width; register 0 reads as zero and is never written.
- OPW, 4, opaque opcode width carried through unchanged.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decoded instruction available.
- in_ready  out  1  instruction accepted this cycle.
- in_srcA, in_srcB  in  RW  source registers; 0 means "unused / zero".
- in_dstE, in_dstM  in  RW  destinations, passed through; 0 means "no write".
- in_op  in  OPW  opcode, passed through.
- rf_srcA, rf_srcB  out  RW  register file read addresses (combinational = in_srcA/in_srcB).
- rf_A, rf_B  in  DW  register file read data (combinational).
- ex_dstE, ex_valE  in  RW/DW  execute-stage ALU result.
- ex_dstM  in  RW  execute-stage load destination; value not yet available.
- mem_dstE, mem_valE, mem_dstM, mem_valM  in  RW/DW  memory-stage results.
- wb_dstE, wb_valE, wb_dstM, wb_valM  in  RW/DW  writeback buses, the same signals that drive the register file write ports.
- flush  in  1  squash held and incoming instruction.
- out_valid  out  1  bundle valid.
- out_ready  in  1  execute accepts bundle.
- out_A, out_B  out  DW  resolved operands.
- out_dstE, out_dstM  out  RW  registered destinations.
- out_op  out  OPW  registered opcode.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_A=out_B=0, out_dstE=out_dstM=0, out_op=0. Outputs hold until first clk edge after release.
- Operand resolution (combinational, per source S, first match wins):
  - S==0 -> 0.
  - ex_dstE==S -> ex_valE.
  - mem_dstM==S -> mem_valM.
  - mem_dstE==S -> mem_valE.
  - wb_dstM==S -> wb_valM.
  - wb_dstE==S -> wb_valE.
  - else rf_A/rf_B.
- M-over-E priority within a stage mirrors the register file rule: when dstE==dstM, the M write wins and the E write is dropped.
- Hazard: hazard=1 when ex_dstM!=0 and (in_srcA==ex_dstM or in_srcB==ex_dstM). Only nonzero sources count.
- Readiness: in_ready = !hazard && !flush && (!out_valid || out_ready).
- Output register update, first applicable case wins:
  - flush -> out_valid<=0; dst fields <=0.
  - in_valid&&in_ready -> load resolved operands, dst, op; out_valid<=1.
  - out_valid&&out_ready -> out_valid<=0; dst fields <=0 (bubble).
  - else hold all.
- Latency: one cycle from acceptance to out_valid.
- Back-to-back issue: full throughput when out_ready=1 and no hazard.
- Stall (out_valid=1, out_ready=0): bundle stable, in_ready=0. Operands are NOT re-resolved while held; the value captured at acceptance is final.
- Load-use: exactly one bubble. Next cycle the load sits in mem, mem_dstM matches and forwards mem_valM.
- Bubbles never carry nonzero dst, so downstream hazard and forward logic stays inert.
- Reset mid-stall: bundle discarded immediately.
- rf_src* pass through even when in_valid=0, which is harmless.

Decomposition:
- Shared package `snail_pkg`: DW, RW, OPW constants; REG_ZERO=3'o0.
- One sub-module `fwd_mux`, instantiated twice (A, B): pure combinational priority selector, inputs S, rf data, 6 forward pairs.
- Hazard, handshake and output register stay in the top.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with out_valid=1 -> out_valid drops immediately, all outputs 0.
- No forwarding: rf r3=8'h5A, src A=3, B=0 -> next cycle out_A=8'h5A, out_B=8'h00, out_valid=1.
- Priority: src A=2; ex_dstE=2/8'h11, mem_dstM=2/8'h22, wb_dstE=2/8'h33 -> out_A=8'h11. Remove ex -> 8'h22. Set wb_dstM=wb_dstE=2 (8'h44/8'h33) only -> 8'h44.
- Load-use: ex_dstM=5, src B=5 -> in_ready=0 one cycle, bubble with out_valid=0 and dst=0. Next cycle mem_dstM=5/8'h9C -> out_B=8'h9C.
- Back-pressure: out_ready=0 for 3 cycles with forwarding sources changing -> out_A/out_B/out_op stable, in_ready=0. Release -> next instruction accepted same cycle.
- Flush: flush=1 with in_valid=1 and out_valid=1 -> in_ready=0, out_valid=0 and out_dstE=0 next cycle.

Source files
------------

// File: rtl/snail_pkg.sv
// Shared widths and constants for the operand-fetch slice of the pipeline.
package snail_pkg;

    localparam int DW  = 8;   // data width, matches the register file
    localparam int RW  = 3;   // register address width (8 registers)
    localparam int OPW = 4;   // opaque opcode width

    // Register 0 always reads as zero and is never written; a destination of
    // zero therefore also means "no write".
    localparam logic [RW-1:0] REG_ZERO = 3'o0;

endpackage

// File: rtl/operand_fetch_if.sv
// Bus bundle around operand_fetch: decoded instruction in, register file read
// ports, forwarding buses from the later stages, and the bundle to execute.
interface operand_fetch_if
    import snail_pkg::*;
#(
    parameter int DW  = snail_pkg::DW,
    parameter int RW  = snail_pkg::RW,
    parameter int OPW = snail_pkg::OPW
);
    // decoded instruction from decode
    logic           in_valid;
    logic           in_ready;
    logic [RW-1:0]  in_srcA;
    logic [RW-1:0]  in_srcB;
    logic [RW-1:0]  in_dstE;
    logic [RW-1:0]  in_dstM;
    logic [OPW-1:0] in_op;

    // register file read ports
    logic [RW-1:0]  rf_srcA;
    logic [RW-1:0]  rf_srcB;
    logic [DW-1:0]  rf_A;
    logic [DW-1:0]  rf_B;

    // in-flight results from execute, memory and writeback
    logic [RW-1:0]  ex_dstE;
    logic [DW-1:0]  ex_valE;
    logic [RW-1:0]  ex_dstM;
    logic [RW-1:0]  mem_dstE;
    logic [DW-1:0]  mem_valE;
    logic [RW-1:0]  mem_dstM;
    logic [DW-1:0]  mem_valM;
    logic [RW-1:0]  wb_dstE;
    logic [DW-1:0]  wb_valE;
    logic [RW-1:0]  wb_dstM;
    logic [DW-1:0]  wb_valM;

    logic           flush;

    // registered operand bundle to execute
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_A;
    logic [DW-1:0]  out_B;
    logic [RW-1:0]  out_dstE;
    logic [RW-1:0]  out_dstM;
    logic [OPW-1:0] out_op;

    // operand_fetch side
    modport slave (
        input  in_valid, in_srcA, in_srcB, in_dstE, in_dstM, in_op,
        output in_ready,
        output rf_srcA, rf_srcB,
        input  rf_A, rf_B,
        input  ex_dstE, ex_valE, ex_dstM,
        input  mem_dstE, mem_valE, mem_dstM, mem_valM,
        input  wb_dstE, wb_valE, wb_dstM, wb_valM,
        input  flush,
        output out_valid, out_A, out_B, out_dstE, out_dstM, out_op,
        input  out_ready
    );

    // surrounding pipeline side (decode, register file, later stages)
    modport master (
        output in_valid, in_srcA, in_srcB, in_dstE, in_dstM, in_op,
        input  in_ready,
        input  rf_srcA, rf_srcB,
        output rf_A, rf_B,
        output ex_dstE, ex_valE, ex_dstM,
        output mem_dstE, mem_valE, mem_dstM, mem_valM,
        output wb_dstE, wb_valE, wb_dstM, wb_valM,
        output flush,
        input  out_valid, out_A, out_B, out_dstE, out_dstM, out_op,
        output out_ready
    );

endinterface

// File: rtl/fwd_mux.sv
// Priority selector for one source operand: the youngest in-flight producer
// wins, and within a stage the M (load) write beats the E (ALU) write, the
// same way the register file resolves a dual write to one register.
module fwd_mux
    import snail_pkg::*;
#(
    parameter int DW = snail_pkg::DW,
    parameter int RW = snail_pkg::RW
) (
    input  logic [RW-1:0] src,
    input  logic [DW-1:0] rf_val,
    input  logic [RW-1:0] ex_dstE,
    input  logic [DW-1:0] ex_valE,
    input  logic [RW-1:0] mem_dstM,
    input  logic [DW-1:0] mem_valM,
    input  logic [RW-1:0] mem_dstE,
    input  logic [DW-1:0] mem_valE,
    input  logic [RW-1:0] wb_dstM,
    input  logic [DW-1:0] wb_valM,
    input  logic [RW-1:0] wb_dstE,
    input  logic [DW-1:0] wb_valE,
    output logic [DW-1:0] val
);

    // First match wins; a zero source short-circuits so idle buses (dst=0)
    // can never leak into an unused operand.
    always_comb begin
        val = rf_val;
        if (src == RW'(REG_ZERO))
            val = '0;
        else if (ex_dstE == src)
            val = ex_valE;
        else if (mem_dstM == src)
            val = mem_valM;
        else if (mem_dstE == src)
            val = mem_valE;
        else if (wb_dstM == src)
            val = wb_valM;
        else if (wb_dstE == src)
            val = wb_valE;
    end

endmodule

// File: rtl/operand_fetch.sv
// Decode-side operand fetch: reads the register file, patches operands with
// in-flight results, stalls on load-use, and registers a valid/ready bundle
// for execute.
module operand_fetch
    import snail_pkg::*;
#(
    parameter int DW  = snail_pkg::DW,
    parameter int RW  = snail_pkg::RW,
    parameter int OPW = snail_pkg::OPW
) (
    input  logic          clk,
    input  logic          rst_n,
    operand_fetch_if.slave bus
);

    logic [DW-1:0]  fwd_a;
    logic [DW-1:0]  fwd_b;
    logic           hazard;
    logic           accept;

    logic           vld_p0;
    logic [DW-1:0]  a_p0;
    logic [DW-1:0]  b_p0;
    logic [RW-1:0]  dste_p0;
    logic [RW-1:0]  dstm_p0;
    logic [OPW-1:0] op_p0;

    // The file only commits at posedge, so writeback must still be forwarded.
    assign bus.rf_srcA = bus.in_srcA;
    assign bus.rf_srcB = bus.in_srcB;

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_a (
        .src      (bus.in_srcA),
        .rf_val   (bus.rf_A),
        .ex_dstE  (bus.ex_dstE),
        .ex_valE  (bus.ex_valE),
        .mem_dstM (bus.mem_dstM),
        .mem_valM (bus.mem_valM),
        .mem_dstE (bus.mem_dstE),
        .mem_valE (bus.mem_valE),
        .wb_dstM  (bus.wb_dstM),
        .wb_valM  (bus.wb_valM),
        .wb_dstE  (bus.wb_dstE),
        .wb_valE  (bus.wb_valE),
        .val      (fwd_a)
    );

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_b (
        .src      (bus.in_srcB),
        .rf_val   (bus.rf_B),
        .ex_dstE  (bus.ex_dstE),
        .ex_valE  (bus.ex_valE),
        .mem_dstM (bus.mem_dstM),
        .mem_valM (bus.mem_valM),
        .mem_dstE (bus.mem_dstE),
        .mem_valE (bus.mem_valE),
        .wb_dstM  (bus.wb_dstM),
        .wb_valM  (bus.wb_valM),
        .wb_dstE  (bus.wb_dstE),
        .wb_valE  (bus.wb_valE),
        .val      (fwd_b)
    );

    // A load in execute has no data yet; a nonzero ex_dstM that matches
    // either source holds the instruction one cycle until it reaches mem.
    always_comb begin
        hazard = 1'b0;
        if (bus.ex_dstM != RW'(REG_ZERO))
            hazard = (bus.in_srcA == bus.ex_dstM) || (bus.in_srcB == bus.ex_dstM);
    end

    assign bus.in_ready = !hazard && !bus.flush && (!vld_p0 || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    // ---- stage p0: operand bundle register toward execute ----
    // Operands are captured only at acceptance; a stalled bundle keeps them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            a_p0    <= '0;
            b_p0    <= '0;
            dste_p0 <= '0;
            dstm_p0 <= '0;
            op_p0   <= '0;
        end else if (bus.flush) begin
            vld_p0  <= 1'b0;
            dste_p0 <= '0;
            dstm_p0 <= '0;
        end else if (accept) begin
            vld_p0  <= 1'b1;
            a_p0    <= fwd_a;
            b_p0    <= fwd_b;
            dste_p0 <= bus.in_dstE;
            dstm_p0 <= bus.in_dstM;
            op_p0   <= bus.in_op;
        end else if (vld_p0 && bus.out_ready) begin
            // bubble: zero destinations keep downstream hazard/forward inert
            vld_p0  <= 1'b0;
            dste_p0 <= '0;
            dstm_p0 <= '0;
        end
    end

    assign bus.out_valid = vld_p0;
    assign bus.out_A     = a_p0;
    assign bus.out_B     = b_p0;
    assign bus.out_dstE  = dste_p0;
    assign bus.out_dstM  = dstm_p0;
    assign bus.out_op    = op_p0;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: accepted instructions push their
// hand-computed bundle, a monitor pops and compares on each output handshake.
module tb_operand_fetch;
    import snail_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    operand_fetch_if bus();

    operand_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // register file stand-in: r0 reads zero, rN reads 8'h57+N (r3 = 8'h5A)
    assign bus.rf_A = (bus.rf_srcA == 3'd0) ? 8'h00 : 8'(8'h57 + bus.rf_srcA);
    assign bus.rf_B = (bus.rf_srcB == 3'd0) ? 8'h00 : 8'(8'h57 + bus.rf_srcB);

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] dste;
        logic [2:0] dstm;
        logic [3:0] op;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // idle buses: dst 0 with nonzero junk values, which must never be chosen
    task automatic idle_fwd();
        bus.ex_dstE  = 3'd0; bus.ex_valE  = 8'hE1; bus.ex_dstM = 3'd0;
        bus.mem_dstE = 3'd0; bus.mem_valE = 8'hE2;
        bus.mem_dstM = 3'd0; bus.mem_valM = 8'hE3;
        bus.wb_dstE  = 3'd0; bus.wb_valE  = 8'hE4;
        bus.wb_dstM  = 3'd0; bus.wb_valM  = 8'hE5;
    endtask

    task automatic drive_in(input logic [2:0] sa, input logic [2:0] sbv,
                            input logic [2:0] de, input logic [2:0] dm, input logic [3:0] op);
        bus.in_valid = 1'b1;
        bus.in_srcA  = sa;
        bus.in_srcB  = sbv;
        bus.in_dstE  = de;
        bus.in_dstM  = dm;
        bus.in_op    = op;
    endtask

    // present an instruction, wait (bounded) for in_ready, push its expected
    // bundle, and return just after the accepting edge
    task automatic issue(input logic [2:0] sa, input logic [2:0] sbv,
                         input logic [2:0] de, input logic [2:0] dm, input logic [3:0] op,
                         input logic [7:0] ea, input logic [7:0] eb);
        int k;
        drive_in(sa, sbv, de, dm, op);
        k = 0;
        @(negedge clk);
        while (!bus.in_ready && k < 20) begin
            k++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL issue_timeout: in_ready stayed 0 for src %0d/%0d", sa, sbv);
        end else begin
            exp_q.push_back('{ea, eb, de, dm, op});
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // monitor: compare each bundle taken by execute against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_bundle: A=%0h B=%0h op=%0h", bus.out_A, bus.out_B, bus.out_op);
                end else begin
                    e = exp_q.pop_front();
                    chk("bundle_A",    32'(bus.out_A),    32'(e.a));
                    chk("bundle_B",    32'(bus.out_B),    32'(e.b));
                    chk("bundle_dstE", 32'(bus.out_dstE), 32'(e.dste));
                    chk("bundle_dstM", 32'(bus.out_dstM), 32'(e.dstm));
                    chk("bundle_op",   32'(bus.out_op),   32'(e.op));
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_srcA   = 3'd0;
        bus.in_srcB   = 3'd0;
        bus.in_dstE   = 3'd0;
        bus.in_dstM   = 3'd0;
        bus.in_op     = 4'd0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        idle_fwd();

        // reset values
        #12;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_A",     32'(bus.out_A),     32'd0);
        chk("rst_B",     32'(bus.out_B),     32'd0);
        chk("rst_dstE",  32'(bus.out_dstE),  32'd0);
        chk("rst_dstM",  32'(bus.out_dstM),  32'd0);
        chk("rst_op",    32'(bus.out_op),    32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // no forwarding: register file value, zero source reads zero
        issue(3'd3, 3'd0, 3'd4, 3'd0, 4'd1, 8'h5A, 8'h00);

        // priority: ex beats mem beats wb
        bus.ex_dstE = 3'd2;  bus.ex_valE = 8'h11;
        bus.mem_dstM = 3'd2; bus.mem_valM = 8'h22;
        bus.wb_dstE = 3'd2;  bus.wb_valE = 8'h33;
        issue(3'd2, 3'd1, 3'd1, 3'd0, 4'd2, 8'h11, 8'h58);
        bus.ex_dstE = 3'd0;
        issue(3'd2, 3'd1, 3'd1, 3'd0, 4'd3, 8'h22, 8'h58);
        idle_fwd();
        bus.wb_dstM = 3'd2; bus.wb_valM = 8'h44;
        bus.wb_dstE = 3'd2; bus.wb_valE = 8'h33;
        issue(3'd2, 3'd0, 3'd0, 3'd2, 4'd4, 8'h44, 8'h00);
        // mem E beats wb E; wb M beats register file
        idle_fwd();
        bus.mem_dstE = 3'd6; bus.mem_valE = 8'h77;
        bus.wb_dstE  = 3'd6; bus.wb_valE  = 8'h88;
        bus.wb_dstM  = 3'd3; bus.wb_valM  = 8'h12;
        issue(3'd6, 3'd3, 3'd2, 3'd0, 4'd5, 8'h77, 8'h12);
        // mem M beats mem E; zero source ignores idle ex bus
        idle_fwd();
        bus.mem_dstM = 3'd7; bus.mem_valM = 8'h66;
        bus.mem_dstE = 3'd7; bus.mem_valE = 8'h99;
        bus.ex_valE  = 8'hFF;
        issue(3'd7, 3'd0, 3'd6, 3'd0, 4'd6, 8'h66, 8'h00);

        // load-use: one stall cycle, one bubble, then mem forwards the load
        idle_fwd();
        bus.ex_dstM = 3'd5;
        drive_in(3'd3, 3'd5, 3'd1, 3'd0, 4'd9);
        @(negedge clk);
        chk("loaduse_in_ready", 32'(bus.in_ready),  32'd0);
        chk("loaduse_prev_vld", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1;
        chk("bubble_valid", 32'(bus.out_valid), 32'd0);
        chk("bubble_dstE",  32'(bus.out_dstE),  32'd0);
        chk("bubble_dstM",  32'(bus.out_dstM),  32'd0);
        bus.ex_dstM  = 3'd0;
        bus.mem_dstM = 3'd5; bus.mem_valM = 8'h9C;
        issue(3'd3, 3'd5, 3'd1, 3'd0, 4'd9, 8'h5A, 8'h9C);

        // back-pressure: held bundle stays put while forwarding changes
        idle_fwd();
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.ex_dstE = 3'd1; bus.ex_valE = 8'hAA;
        issue(3'd1, 3'd2, 3'd3, 3'd4, 4'd7, 8'hAA, 8'h59);
        drive_in(3'd1, 3'd2, 3'd5, 3'd0, 4'd8);
        for (int c = 0; c < 3; c++) begin
            bus.ex_dstE  = 3'd1; bus.ex_valE  = 8'(8'hB0 + c);
            bus.mem_dstM = 3'd2; bus.mem_valM = 8'(8'hC0 + c);
            @(negedge clk);
            chk("stall_A",        32'(bus.out_A),     32'hAA);
            chk("stall_B",        32'(bus.out_B),     32'h59);
            chk("stall_op",       32'(bus.out_op),    32'd7);
            chk("stall_valid",    32'(bus.out_valid), 32'd1);
            chk("stall_in_ready", 32'(bus.in_ready),  32'd0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        issue(3'd1, 3'd2, 3'd5, 3'd0, 4'd8, 8'hB2, 8'hC2);

        // flush with a held bundle and an incoming instruction
        bus.out_ready = 1'b0;
        bus.flush = 1'b1;
        drive_in(3'd3, 3'd0, 3'd2, 3'd0, 4'd1);
        @(negedge clk);
        chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_dstE",  32'(bus.out_dstE),  32'd0);
        chk("flush_dstM",  32'(bus.out_dstM),  32'd0);
        exp_q.delete();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        idle_fwd();
        issue(3'd4, 3'd4, 3'd1, 3'd1, 4'd3, 8'h5B, 8'h5B);

        // reset while a bundle is stalled: discarded immediately
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("prerst_valid", 32'(bus.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_A",     32'(bus.out_A),     32'd0);
        chk("midrst_B",     32'(bus.out_B),     32'd0);
        chk("midrst_dstE",  32'(bus.out_dstE),  32'd0);
        chk("midrst_dstM",  32'(bus.out_dstM),  32'd0);
        chk("midrst_op",    32'(bus.out_op),    32'd0);
        exp_q.delete();
        #3 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        issue(3'd3, 3'd0, 3'd0, 3'd0, 4'd1, 8'h5A, 8'h00);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
